// File: rtl/bsg_catmap_pkg.sv
// Shared types for the cat-map engine and its job arbiter: FSM states, job record, width helper.
package bsg_catmap_pkg;

    function automatic int bsg_safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    localparam int catmap_max_game_length_lp = 256;
    localparam int catmap_glw_lp             = bsg_safe_clog2(catmap_max_game_length_lp + 1);

    typedef enum logic [1:0] {
        eIDLE  = 2'd0,
        eISSUE = 2'd1,
        eWAIT  = 2'd2,
        eRESP  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic [catmap_glw_lp-1:0] frames;
        logic                     decrypt;
    } catmap_job_s;

endpackage

// File: rtl/bsg_catmap_job_arbiter_if.sv
// Requester-side and engine-side channels of the cat-map job arbiter.
// master = arbiter view, slave = requesters/engine view.
interface bsg_catmap_job_arbiter_if
    import bsg_catmap_pkg::*;
#(
    parameter int num_req_p         = 2,
    parameter int max_game_length_p = catmap_max_game_length_lp
) ();
    localparam int glw = bsg_safe_clog2(max_game_length_p + 1);
    localparam int lw  = bsg_safe_clog2(num_req_p);

    logic [num_req_p-1:0]     req_v_i;
    logic [num_req_p*glw-1:0] req_frames_i;
    logic [num_req_p-1:0]     req_decrypt_i;
    logic [num_req_p-1:0]     req_ready_o;
    logic [num_req_p-1:0]     resp_v_o;
    logic                     resp_err_o;
    logic [num_req_p-1:0]     resp_yumi_i;
    logic                     eng_v_o;
    logic [glw-1:0]           eng_frames_o;
    logic                     eng_decrypt_o;
    logic                     eng_ready_i;
    logic                     eng_v_i;
    logic                     eng_yumi_o;
    logic                     eng_abort_o;
    logic [lw-1:0]            owner_o;

    modport master (
        input  req_v_i, req_frames_i, req_decrypt_i, resp_yumi_i, eng_ready_i, eng_v_i,
        output req_ready_o, resp_v_o, resp_err_o, eng_v_o, eng_frames_o, eng_decrypt_o,
               eng_yumi_o, eng_abort_o, owner_o
    );

    modport slave (
        output req_v_i, req_frames_i, req_decrypt_i, resp_yumi_i, eng_ready_i, eng_v_i,
        input  req_ready_o, resp_v_o, resp_err_o, eng_v_o, eng_frames_o, eng_decrypt_o,
               eng_yumi_o, eng_abort_o, owner_o
    );

endinterface

// File: rtl/bsg_catmap_rr_picker.sv
// Round-robin pick: first set request at or after rr_ptr_i, wrapping.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module bsg_catmap_rr_picker
    import bsg_catmap_pkg::*;
#(
    parameter int num_req_p = 2,
    parameter int lw_p      = bsg_safe_clog2(num_req_p)
) (
    input  logic [num_req_p-1:0] req_i,
    input  logic [lw_p-1:0]      rr_ptr_i,
    output logic [num_req_p-1:0] grant_oh_o,
    output logic [lw_p-1:0]      grant_idx_o,
    output logic                 any_v_o
);

    logic [lw_p-1:0] w_idx [num_req_p];

    // w_idx[k] is the requester examined k-th, i.e. the rotation of the request vector.
    always_comb begin
        for (int k = 0; k < num_req_p; k++) begin
            w_idx[k] = lw_p'((int'(rr_ptr_i) + k) % num_req_p);
        end
    end

    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        any_v_o     = 1'b0;
        for (int k = 0; k < num_req_p; k++) begin
            if (!any_v_o && req_i[w_idx[k]]) begin
                any_v_o              = 1'b1;
                grant_oh_o[w_idx[k]] = 1'b1;
                grant_idx_o          = w_idx[k];
            end
        end
    end

endmodule

// File: rtl/bsg_catmap_job_arbiter.sv
// Shares one cat-map engine among num_req_p requesters, one job in flight, round-robin.
// Latency: req handshake -> eng_v_o 1 cycle; zero-frame job -> resp_v_o 1 cycle.
// Backpressure: holds eng_v_o until eng_ready_i, resp_v_o until owner yumi; optional CATMAP_ARB_WATCHDOG_EN.
module bsg_catmap_job_arbiter
    import bsg_catmap_pkg::*;
#(
    parameter int num_req_p         = 2,
    parameter int max_game_length_p = catmap_max_game_length_lp,
    parameter int watchdog_cycles_p = 4096
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    bsg_catmap_job_arbiter_if.master io
);

    localparam int glw = bsg_safe_clog2(max_game_length_p + 1);
    localparam int lw  = bsg_safe_clog2(num_req_p);

    arb_state_e           r_state;
    arb_state_e           w_state_nxt;
    logic [lw-1:0]        r_rr_ptr;
    logic [lw-1:0]        r_owner;
    catmap_job_s          r_job;
    logic                 r_err;

    logic [num_req_p-1:0] w_grant_oh;
    logic [lw-1:0]        w_grant_idx;
    logic                 w_any_v;
    logic [glw-1:0]       w_frames_sel;
    logic                 w_decrypt_sel;
    logic [num_req_p-1:0] w_owner_oh;
    logic                 w_req_hs;
    logic                 w_resp_hs;
    logic                 w_timeout;

    bsg_catmap_rr_picker #(
        .num_req_p (num_req_p),
        .lw_p      (lw)
    ) u_picker (
        .req_i       (io.req_v_i),
        .rr_ptr_i    (r_rr_ptr),
        .grant_oh_o  (w_grant_oh),
        .grant_idx_o (w_grant_idx),
        .any_v_o     (w_any_v)
    );

    always_comb begin
        w_frames_sel  = '0;
        w_decrypt_sel = 1'b0;
        for (int r = 0; r < num_req_p; r++) begin
            if (w_grant_idx == lw'(r)) begin
                w_frames_sel  = io.req_frames_i[r*glw +: glw];
                w_decrypt_sel = io.req_decrypt_i[r];
            end
        end
    end

    always_comb begin
        w_owner_oh          = '0;
        w_owner_oh[r_owner] = 1'b1;
    end

    assign w_req_hs  = (r_state == eIDLE) && w_any_v;
    assign w_resp_hs = (r_state == eRESP) && io.resp_yumi_i[r_owner];

`ifdef CATMAP_ARB_WATCHDOG_EN
    localparam int wdw = bsg_safe_clog2(watchdog_cycles_p);

    logic [wdw-1:0] r_wd_cnt;

    // Held at zero outside WAIT, so every WAIT visit starts counting from 0.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wd_cnt <= '0;
        end else if (r_state != eWAIT) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + wdw'(1);
        end
    end

    assign w_timeout = (r_state == eWAIT) && (r_wd_cnt == wdw'(watchdog_cycles_p - 1));
`else
    // Without the watchdog the timeout can never fire; the cycle limit has no effect.
    assign w_timeout = (watchdog_cycles_p < 0);
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= eIDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            eIDLE:   if (w_req_hs) w_state_nxt = (w_frames_sel == '0) ? eRESP : eISSUE;
            eISSUE:  if (io.eng_ready_i) w_state_nxt = eWAIT;
            eWAIT:   if (io.eng_v_i || w_timeout) w_state_nxt = eRESP;
            eRESP:   if (w_resp_hs) w_state_nxt = eIDLE;
            default: w_state_nxt = eIDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_job    <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_req_hs) begin
                r_owner       <= w_grant_idx;
                r_job.frames  <= catmap_glw_lp'(w_frames_sel);
                r_job.decrypt <= w_decrypt_sel;
                r_err         <= 1'b0;
            end
            // A done arriving on the timeout cycle wins over the timeout.
            if (r_state == eWAIT) begin
                if (io.eng_v_i) begin
                    r_err <= 1'b0;
                end else if (w_timeout) begin
                    r_err <= 1'b1;
                end
            end
            if (w_resp_hs) begin
                r_rr_ptr <= (r_owner == lw'(num_req_p - 1)) ? '0 : r_owner + lw'(1);
            end
        end
    end

    always_comb begin
        io.req_ready_o   = (r_state == eIDLE) ? w_grant_oh : '0;
        io.eng_v_o       = (r_state == eISSUE);
        io.eng_frames_o  = glw'(r_job.frames);
        io.eng_decrypt_o = r_job.decrypt;
        io.eng_yumi_o    = (r_state == eWAIT) && io.eng_v_i;
        io.eng_abort_o   = w_timeout && !io.eng_v_i;
        io.resp_v_o      = (r_state == eRESP) ? w_owner_oh : '0;
        io.resp_err_o    = (r_state == eRESP) && r_err;
        io.owner_o       = r_owner;
    end

endmodule

// File: tb/tb_bsg_catmap_job_arbiter.sv
// Directed + randomized bench for bsg_catmap_job_arbiter against a round-robin job model.
// Watchdog steps run only when CATMAP_ARB_WATCHDOG_EN is defined.
module tb_bsg_catmap_job_arbiter;
    import bsg_catmap_pkg::*;

    localparam int N   = 2;
    localparam int MGL = 256;
    localparam int GLW = bsg_safe_clog2(MGL + 1);
    localparam int WD  = 16;

    logic clk_i     = 1'b0;
    logic reset_n_i = 1'b0;
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   exp_ptr   = 0;

    always #5 clk_i = ~clk_i;

    bsg_catmap_job_arbiter_if #(.num_req_p(N), .max_game_length_p(MGL)) io ();

    bsg_catmap_job_arbiter #(
        .num_req_p         (N),
        .max_game_length_p (MGL),
        .watchdog_cycles_p (WD)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .io        (io)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Model: serve the first requesting index at or after the pointer (wrapping).
    function automatic int model_grant(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check(tag, {io.req_ready_o, io.resp_v_o, io.resp_err_o, io.eng_v_o, io.eng_frames_o,
                    io.eng_decrypt_o, io.eng_yumi_o, io.eng_abort_o, io.owner_o}, 32'd0);
    endtask

    task automatic run_job(input logic [N-1:0] mask, input logic [N*GLW-1:0] frames,
                           input logic [N-1:0] dec, input int rdy_dly, input int done_dly,
                           input bit bad_yumi, input bit expect_err);
        int             g;
        logic [N-1:0]   goh;
        logic [GLW-1:0] f;
        io.req_v_i       = mask;
        io.req_frames_i  = frames;
        io.req_decrypt_i = dec;
        #1;
        g   = model_grant(mask, exp_ptr);
        goh = N'(1) << g;
        f   = frames[g*GLW +: GLW];
        check("req_ready", io.req_ready_o, goh);
        tick();
        io.req_v_i = '0;
        check("owner", io.owner_o, g);
        if (f == '0) begin
            check("zero_len_no_eng_v", io.eng_v_o, 0);
        end else begin
            for (int c = 0; c < rdy_dly; c++) begin
                io.eng_v_i = 1'($urandom_range(0, 1));
                #1;
                check("issue_stable", {io.eng_v_o, io.eng_frames_o, io.eng_decrypt_o}, {1'b1, f, dec[g]});
                check("yumi_outside_wait", io.eng_yumi_o, 0);
                tick();
            end
            io.eng_v_i     = 1'b0;
            io.eng_ready_i = 1'b1;
            #1;
            check("issue_accept", {io.eng_v_o, io.eng_frames_o, io.eng_decrypt_o}, {1'b1, f, dec[g]});
            tick();
            io.eng_ready_i = 1'b0;
            check("wait_eng_v_low", io.eng_v_o, 0);
            if (expect_err) begin
                for (int c = 1; c <= WD; c++) begin
                    check("abort_timing", io.eng_abort_o, (c == WD) ? 1 : 0);
                    check("wait_no_resp", io.resp_v_o, 0);
                    tick();
                end
            end else begin
                for (int c = 0; c < done_dly; c++) begin
                    check("wait_no_resp", {io.resp_v_o, io.eng_yumi_o, io.eng_abort_o}, 0);
                    tick();
                end
                io.eng_v_i = 1'b1;
                #1;
                check("eng_yumi", io.eng_yumi_o, 1);
                tick();
                io.eng_v_i = 1'b0;
            end
        end
        check("resp_v", io.resp_v_o, goh);
        check("resp_err", io.resp_err_o, expect_err);
        if (bad_yumi) begin
            io.resp_yumi_i = ~goh;
            tick();
            check("resp_hold_bad_yumi", io.resp_v_o, goh);
        end
        io.resp_yumi_i = goh;
        io.req_v_i     = mask;
        #1;
        check("no_accept_on_retire", io.req_ready_o, 0);
        tick();
        io.resp_yumi_i = '0;
        io.req_v_i     = '0;
        check("resp_retired", io.resp_v_o, 0);
        exp_ptr = (g + 1) % N;
    endtask

    initial begin
        io.req_v_i       = '0;
        io.req_frames_i  = '0;
        io.req_decrypt_i = '0;
        io.resp_yumi_i   = '0;
        io.eng_ready_i   = 1'b0;
        io.eng_v_i       = 1'b0;
        #1;
        check_all_zero("reset_outputs");
        tick();
        tick();
        reset_n_i = 1'b1;
        #1;
        check_all_zero("post_reset_outputs");

        // Reset while the engine is busy.
        io.req_v_i      = 2'b01;
        io.req_frames_i = {9'd0, 9'd5};
        #1;
        tick();
        io.req_v_i     = '0;
        io.eng_ready_i = 1'b1;
        tick();
        io.eng_ready_i = 1'b0;
        tick();
        check("in_wait", {io.eng_v_o, io.resp_v_o}, 0);
        reset_n_i = 1'b0;
        #1;
        check_all_zero("mid_wait_reset");
        tick();
        reset_n_i = 1'b1;
        #1;
        check_all_zero("after_mid_wait_reset");
        exp_ptr = 0;

        // Zero-length job from requester 1, with a non-owner yumi that must be ignored.
        run_job(2'b10, {9'd0, 9'd7}, 2'b01, 0, 0, 1'b1, 1'b0);

        // Both requesting: grants alternate, one job with a slow engine accept.
        for (int i = 0; i < 4; i++) begin
            run_job(2'b11, {9'd3, 9'd3}, 2'(i), (i == 1) ? 5 : 0, 1, 1'b0, 1'b0);
        end

        for (int i = 0; i < 24; i++) begin
            run_job(2'($urandom_range(1, 3)),
                    {9'($urandom_range(0, 6)), 9'($urandom_range(0, 6))},
                    2'($urandom_range(0, 3)),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'b0);
        end

`ifdef CATMAP_ARB_WATCHDOG_EN
        run_job(2'b01, {9'd4, 9'd4}, 2'b00, 0, 0, 1'b0, 1'b1);
        run_job(2'b01, {9'd4, 9'd4}, 2'b01, 0, 2, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
